window_accumulator: RTL and testbench

Registered sliding-window accumulator for the stereo cost-aggregation path. It keeps a running sum of the last WINDOW accepted samples: each new sample is added and the sample leaving the window is subtracted, using an internal circular delay line. This replaces the external add/subtract-plus-delay arrangement in the box-filter stages. It has a valid qualifier, a line-start clear and a window-full indication.

---
 rtl/winacc_pkg.sv | 24 ++
 rtl/winacc_delay_line.sv | 44 ++++
 rtl/window_accumulator.sv | 84 ++++++++
 tb/tb_window_accumulator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/winacc_pkg.sv
// rtl/winacc_pkg.sv - shared constants, clog2 helper and SUM_W legality check for window_accumulator
package winacc_pkg;

  localparam int unsigned DEF_IN_W   = 12;
  localparam int unsigned DEF_SUM_W  = 16;
  localparam int unsigned DEF_WINDOW = 8;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// A running sum of WINDOW samples of IN_W bits needs IN_W + clog2(WINDOW) bits.
`define WINACC_CHECK_SUM_W(in_w, sum_w, window) \
  if ((sum_w) < (in_w) + winacc_pkg::clog2(window)) begin : g_sum_w_check \
    $error("window_accumulator: SUM_W too narrow for IN_W and WINDOW"); \
  end

// File: rtl/winacc_delay_line.sv
// rtl/winacc_delay_line.sv - circular WINDOW x IN_W buffer with read-first port and wrapping write pointer
module winacc_delay_line
  import winacc_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic            restart,
  input  logic [IN_W-1:0] wr_data,
  output logic [IN_W-1:0] old_data
);

  localparam int unsigned PTR_W = clog2(WINDOW);

  logic [IN_W-1:0]  mem [WINDOW];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] wptr_inc;

  // Oldest entry is read at the current pointer before this cycle's write lands.
  assign old_data = mem[wptr];
  assign wr_addr  = restart ? '0 : wptr;
  assign wptr_inc = (wr_addr == PTR_W'(WINDOW - 1)) ? '0 : wr_addr + 1'b1;

  // Storage is never reset; stale entries are masked by the fill count upstream.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write pointer: restart rewinds to 0, an accepted write advances with wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
    end else if (wr_en) begin
      wptr <= wptr_inc;
    end else if (restart) begin
      wptr <= '0;
    end
  end

endmodule

// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - sliding-window running sum with clear and full flag; WINACC_MEAN_EN adds out_mean
module window_accumulator
  import winacc_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned SUM_W  = DEF_SUM_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_full
`ifdef WINACC_MEAN_EN
  ,
  output logic [SUM_W-1:0] out_mean
`endif
);

  localparam int unsigned FILL_W = clog2(WINDOW + 1);

  `WINACC_CHECK_SUM_W(IN_W, SUM_W, WINDOW)

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [IN_W-1:0]   old_data;
  logic [SUM_W-1:0]  old_term;
  logic [SUM_W-1:0]  sum_next;
  logic              is_full;

  winacc_delay_line #(
    .IN_W   (IN_W),
    .WINDOW (WINDOW)
  ) u_delay_line (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (in_valid),
    .restart  (clear),
    .wr_data  (in_data),
    .old_data (old_data)
  );

  // Next fill/sum for an accepted sample; the leaving sample only counts once the window is full.
  always_comb begin
    is_full   = (fill == FILL_W'(WINDOW));
    fill_next = is_full ? fill : fill + 1'b1;
    old_term  = is_full ? SUM_W'(old_data) : '0;
    sum_next  = out_sum + SUM_W'(in_data) - old_term;
  end

  // Fill counter and output registers; clear wins, and a coincident sample opens the new window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill      <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
    end else if (clear) begin
      fill      <= in_valid ? FILL_W'(1) : '0;
      out_sum   <= in_valid ? SUM_W'(in_data) : '0;
      out_valid <= in_valid;
      out_full  <= 1'b0;
    end else if (in_valid) begin
      fill      <= fill_next;
      out_sum   <= sum_next;
      out_valid <= 1'b1;
      out_full  <= (fill_next == FILL_W'(WINDOW));
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef WINACC_MEAN_EN
  if ((WINDOW & (WINDOW - 1)) != 0) begin : g_pow2_check
    $error("window_accumulator: WINDOW must be a power of two with WINACC_MEAN_EN");
  end

  assign out_mean = out_sum >> clog2(WINDOW);
`endif

endmodule

// File: tb/tb_window_accumulator.sv
// tb/tb_window_accumulator.sv - randomized and directed bench for window_accumulator against a queue model
module tb_window_accumulator;

  localparam int IN_W   = 12;
  localparam int SUM_W  = 16;
  localparam int WINDOW = 4;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear   = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic [SUM_W-1:0] out_sum;
  logic             out_full;
`ifdef WINACC_MEAN_EN
  logic [SUM_W-1:0] out_mean;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the accepted samples of the current window, newest at the back.
  int window_q[$];

  window_accumulator #(
    .IN_W   (IN_W),
    .SUM_W  (SUM_W),
    .WINDOW (WINDOW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_full  (out_full)
`ifdef WINACC_MEAN_EN
    ,
    .out_mean  (out_mean)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input longint observed, input longint expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (window_q[i]) s += window_q[i];
    return s % (1 << SUM_W);
  endfunction

  task automatic check_outputs(input string tag, input bit exp_valid);
    int s;
    s = model_sum();
    check_value({tag, ".valid"}, out_valid, exp_valid);
    check_value({tag, ".sum"}, out_sum, s);
    check_value({tag, ".full"}, out_full, window_q.size() == WINDOW);
`ifdef WINACC_MEAN_EN
    check_value({tag, ".mean"}, out_mean, s / WINDOW);
`endif
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input bit v, input int d, input bit c);
    @(negedge clock);
    in_valid = v;
    in_data  = IN_W'(d);
    clear    = c;
    @(posedge clock);
    #1;
    if (c) window_q.delete();
    if (v) begin
      window_q.push_back(d);
      if (window_q.size() > WINDOW) void'(window_q.pop_front());
    end
    check_outputs(tag, v);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Ramp 1..6 back to back.
    for (int i = 1; i <= 6; i++) step("ramp", 1'b1, i, 1'b0);
    check_value("ramp_final_sum", out_sum, 18);
    step("clr0", 1'b0, 0, 1'b1);
    check_value("clr0_sum", out_sum, 0);

    // Same ramp with a 3-cycle gap after the third sample.
    for (int i = 1; i <= 3; i++) step("gap_a", 1'b1, i, 1'b0);
    for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 0, 1'b0);
    check_value("gap_hold_sum", out_sum, 6);
    for (int i = 4; i <= 6; i++) step("gap_b", 1'b1, i, 1'b0);
    step("clr1", 1'b0, 0, 1'b1);

    // Maximum samples: no wrap at the top of the range.
    for (int i = 0; i < 6; i++) step("max", 1'b1, 4095, 1'b0);
    check_value("max_final_sum", out_sum, 16380);
    step("clr2", 1'b0, 0, 1'b1);

    // Clear coincident with a sample restarts the window with that sample.
    for (int i = 1; i <= 5; i++) step("pre_clr", 1'b1, 10 * i, 1'b0);
    step("clr_sample", 1'b1, 7, 1'b1);
    check_value("clr_sample_sum", out_sum, 7);
    check_value("clr_sample_full", out_full, 0);
    for (int i = 0; i < 3; i++) step("post_clr", 1'b1, 1, 1'b0);
    check_value("post_clr_full", out_full, 1);
    step("clr3", 1'b0, 0, 1'b1);

    // Asynchronous reset mid-window.
    for (int i = 1; i <= 5; i++) step("pre_rst", 1'b1, i, 1'b0);
    check_value("pre_rst_sum", out_sum, 14);
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    window_q.delete();
    check_outputs("async_rst", 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step("post_rst", 1'b1, 9, 1'b0);
    step("post_rst", 1'b1, 9, 1'b0);
    check_value("post_rst_sum", out_sum, 18);

    // Randomized traffic with occasional clears and full-scale samples.
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int d;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095));
      step("rand", v, d, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
